// File: rtl/pad_io_conditioner.sv
// pad_io_conditioner: one pad cell per IO, plus registered and conditioned
// paths between the SoC pad mux and the chip pads.
// Outputs:  output data/enable registers with a global freeze.
// Inputs:   per-pad synchroniser, optional debounce filter, edge-event pulses.

// Behavioural pad cell with an active-low pull-down enable.
// In two-state simulation an undriven pad already resolves low, which is
// what the pull-down gives in silicon, so PEN has no behavioural effect here.
module pad_functional_pd (
  input  logic OEN,
  input  logic I,
  input  logic PEN,
  output logic O,
  inout  wire  PAD
);
  logic pen_unused_s;

  assign PAD          = OEN ? 1'bz : I;
  assign O            = PAD;
  assign pen_unused_s = PEN;
endmodule

module pad_io_conditioner #(
  parameter int N_IO        = 64,
  parameter int NBIT_PADCFG = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_W  = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_IO-1:0][NBIT_PADCFG-1:0]    pad_cfg_i,
  input  logic [DEBOUNCE_W-1:0]               filt_thresh_i,
  input  logic                                freeze_i,
  input  logic [N_IO-1:0]                     io_out_i,
  input  logic [N_IO-1:0]                     io_oe_i,
  output logic [N_IO-1:0]                     io_in_o,
  output logic [N_IO-1:0]                     io_edge_o,
  inout  wire  [N_IO-1:0]                     io
);

  // Pad-side signals
  logic [N_IO-1:0] oen_s;
  logic [N_IO-1:0] pad_i_s;
  logic [N_IO-1:0] pen_s;
  logic [N_IO-1:0] pad_o_s;

  // Output path registers
  logic [N_IO-1:0] oe_q,  oe_d;
  logic [N_IO-1:0] out_q, out_d;

  // Input path registers
  logic [SYNC_STAGES-1:0][N_IO-1:0] sync_q, sync_d;
  logic [N_IO-1:0]                  in_q,   in_d;
  logic [N_IO-1:0]                  edge_q, edge_d;
  logic [N_IO-1:0][DEBOUNCE_W-1:0]  cnt_q,  cnt_d;

  logic [N_IO-1:0]       sync_s;
  logic [DEBOUNCE_W-1:0] te_m1_s;
  logic                  cfg_unused_s;

  // Only bits [3:0] of each pad config are meaningful; the rest are ignored.
  assign cfg_unused_s = ^pad_cfg_i;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign oen_s    = ~oe_q;
  assign pad_i_s  = out_q;
  assign io_in_o  = in_q;
  assign io_edge_o = edge_q;

  // Pull enable is active-low at the cell and follows config with no register.
  always_comb begin
    pen_s = {N_IO{1'b1}};
    for (int k = 0; k < N_IO; k++) begin
      pen_s[k] = ~pad_cfg_i[k][0];
    end
  end

  // Effective threshold minus one: a programmed 0 behaves like 1.
  always_comb begin
    te_m1_s = {DEBOUNCE_W{1'b0}};
    if (filt_thresh_i == {DEBOUNCE_W{1'b0}}) begin
      te_m1_s = {DEBOUNCE_W{1'b0}};
    end else begin
      te_m1_s = filt_thresh_i - DEBOUNCE_W'(1);
    end
  end

  // Output registers load every cycle unless frozen.
  always_comb begin
    oe_d  = oe_q;
    out_d = out_q;
    if (freeze_i) begin
      oe_d  = oe_q;
      out_d = out_q;
    end else begin
      oe_d  = io_oe_i;
      out_d = io_out_i;
    end
  end

  // Input conditioning: synchroniser shift, debounce filter, edge detection.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_o_s};
    in_d   = in_q;
    cnt_d  = cnt_q;
    edge_d = {N_IO{1'b0}};
    for (int k = 0; k < N_IO; k++) begin
      if (!pad_cfg_i[k][1]) begin
        // Bypass: follow the synchroniser, keep the counter parked at zero.
        in_d[k]  = sync_s[k];
        cnt_d[k] = {DEBOUNCE_W{1'b0}};
      end else if (sync_s[k] == in_q[k]) begin
        // Any sample agreeing with the current value restarts the count.
        cnt_d[k] = {DEBOUNCE_W{1'b0}};
      end else if (cnt_q[k] >= te_m1_s) begin
        // Mismatch held long enough (also covers a threshold lowered mid-count).
        in_d[k]  = sync_s[k];
        cnt_d[k] = {DEBOUNCE_W{1'b0}};
      end else begin
        cnt_d[k] = cnt_q[k] + DEBOUNCE_W'(1);
      end

      // Pulse in the cycle the new value first appears, filtered by edge mode.
      if (in_d[k] != in_q[k]) begin
        if (in_d[k]) begin
          edge_d[k] = pad_cfg_i[k][2];
        end else begin
          edge_d[k] = pad_cfg_i[k][3];
        end
      end else begin
        edge_d[k] = 1'b0;
      end
    end
  end

  // State registers; reset tri-states every pad and clears the input path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oe_q   <= {N_IO{1'b0}};
      out_q  <= {N_IO{1'b0}};
      sync_q <= {(SYNC_STAGES*N_IO){1'b0}};
      in_q   <= {N_IO{1'b0}};
      edge_q <= {N_IO{1'b0}};
      cnt_q  <= {(N_IO*DEBOUNCE_W){1'b0}};
    end else begin
      oe_q   <= oe_d;
      out_q  <= out_d;
      sync_q <= sync_d;
      in_q   <= in_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  // One pad cell per IO.
  for (genvar k = 0; k < N_IO; k++) begin : g_pad
    pad_functional_pd u_pad (
      .OEN (oen_s[k]),
      .I   (pad_i_s[k]),
      .PEN (pen_s[k]),
      .O   (pad_o_s[k]),
      .PAD (io[k])
    );
  end

endmodule

// File: tb/tb_pad_io_conditioner.sv
// Self-checking bench for pad_io_conditioner: directed scenarios plus a
// randomized run, all compared against a cycle-level reference model.
module tb_pad_io_conditioner;
  localparam int N  = 64;
  localparam int NB = 6;
  localparam int SS = 2;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic [N-1:0][NB-1:0] cfg;
  logic [DW-1:0]        thr;
  logic                 freeze;
  logic [N-1:0]         out_i, oe_i, in_o, edge_o;
  wire  [N-1:0]         io;
  logic [N-1:0]         tb_en, tb_val;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N-1:0]  m_in, m_edge, m_oe, m_out;
  logic [SS-1:0] m_hist [N];
  int            m_run  [N];

  pad_io_conditioner #(.N_IO(N), .NBIT_PADCFG(NB), .SYNC_STAGES(SS), .DEBOUNCE_W(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .pad_cfg_i(cfg), .filt_thresh_i(thr),
    .freeze_i(freeze), .io_out_i(out_i), .io_oe_i(oe_i),
    .io_in_o(in_o), .io_edge_o(edge_o), .io(io)
  );

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign io[g] = tb_en[g] ? tb_val[g] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic model_reset();
    m_in = '0; m_edge = '0; m_oe = '0; m_out = '0;
    for (int k = 0; k < N; k++) begin
      m_hist[k] = '0;
      m_run[k]  = 0;
    end
  endtask

  // One rising edge of the reference: pad sampled value becomes visible to the
  // filter SS edges later; filter needs Te consecutive differing samples.
  task automatic model_step();
    logic [N-1:0] eff;
    logic         s_old, nv;
    int           te;
    te = (thr == 0) ? 1 : int'(thr);
    for (int k = 0; k < N; k++) begin
      eff[k] = tb_en[k] ? tb_val[k] : (m_oe[k] ? m_out[k] : 1'b0);
      s_old  = m_hist[k][SS-1];
      m_hist[k] = {m_hist[k][SS-2:0], eff[k]};
      nv = m_in[k];
      if (!cfg[k][1]) begin
        m_run[k] = 0;
        nv = s_old;
      end else if (s_old == m_in[k]) begin
        m_run[k] = 0;
      end else begin
        m_run[k] = m_run[k] + 1;
        if (m_run[k] >= te) begin
          nv = s_old;
          m_run[k] = 0;
        end
      end
      m_edge[k] = (nv != m_in[k]) && ((nv && cfg[k][2]) || (!nv && cfg[k][3]));
      m_in[k] = nv;
    end
    if (!freeze) begin
      m_oe  = oe_i;
      m_out = out_i;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_ni) model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; cfg = '0; thr = '0; freeze = 1'b0;
    out_i = '0; oe_i = '0; tb_en = '1; tb_val = '0;
    model_reset();
    cfg[1][0] = 1'b1;
    #2;
    checks++; if (in_o !== '0) begin errors++; $display("FAIL reset_in: got %h expected 0", in_o); end
    checks++; if (edge_o !== '0) begin errors++; $display("FAIL reset_edge: got %h expected 0", edge_o); end
    checks++; if (dut.oen_s !== '1) begin errors++; $display("FAIL reset_oen: got %h expected all ones", dut.oen_s); end
    checks++; if (dut.pad_i_s !== '0) begin errors++; $display("FAIL reset_padi: got %h expected 0", dut.pad_i_s); end
    checks++; if (dut.pen_s[1] !== 1'b0) begin errors++; $display("FAIL reset_pen: got %b expected 0", dut.pen_s[1]); end
    cfg[1][0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (4) tick();
    checks++; if (in_o !== '0) begin errors++; $display("FAIL post_reset_in: got %h expected 0", in_o); end
    checks++; if (dut.oen_s !== '1) begin errors++; $display("FAIL post_reset_oen: got %h expected all ones", dut.oen_s); end
  endtask

  task automatic test_bypass();
    tb_val[5] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (in_o[5] !== (e >= 3)) begin errors++; $display("FAIL bypass_lat e=%0d: got %b expected %b", e, in_o[5], (e >= 3)); end
      checks++;
      if (in_o !== m_in) begin errors++; $display("FAIL bypass_model: got %h expected %h", in_o, m_in); end
    end
  endtask

  task automatic test_debounce();
    cfg[7] = 6'b000010; thr = 8'd4;
    repeat (2) tick();
    tb_val[7] = 1'b1;
    repeat (3) tick();
    tb_val[7] = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      checks++;
      if (in_o[7] !== 1'b0) begin errors++; $display("FAIL glitch_suppress e=%0d: got %b expected 0", e, in_o[7]); end
    end
    tb_val[7] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (in_o[7] !== (e >= 6)) begin errors++; $display("FAIL debounce_lat e=%0d: got %b expected %b", e, in_o[7], (e >= 6)); end
    end
    tb_val[7] = 1'b0;
    repeat (8) tick();
    checks++; if (in_o[7] !== 1'b0) begin errors++; $display("FAIL debounce_fall: got %b expected 0", in_o[7]); end
    thr = 8'd0;
    tb_val[7] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (in_o[7] !== (e >= 3)) begin errors++; $display("FAIL thr0_lat e=%0d: got %b expected %b", e, in_o[7], (e >= 3)); end
    end
  endtask

  task automatic test_edge_modes();
    for (int m = 0; m < 4; m++) begin
      int n_rise, n_fall;
      logic [1:0] mb;
      mb = m[1:0];
      n_rise = 0; n_fall = 0;
      cfg[3] = {2'b00, mb, 2'b00};
      tb_val[3] = 1'b1;
      repeat (6) begin
        tick();
        if (edge_o[3]) n_rise++;
        checks++;
        if (edge_o[3] !== m_edge[3] || in_o[3] !== m_in[3]) begin
          errors++; $display("FAIL edge_rise_align mode=%0d: got e=%b i=%b expected e=%b i=%b", m, edge_o[3], in_o[3], m_edge[3], m_in[3]);
        end
      end
      tb_val[3] = 1'b0;
      repeat (6) begin
        tick();
        if (edge_o[3]) n_fall++;
        checks++;
        if (edge_o[3] !== m_edge[3] || in_o[3] !== m_in[3]) begin
          errors++; $display("FAIL edge_fall_align mode=%0d: got e=%b i=%b expected e=%b i=%b", m, edge_o[3], in_o[3], m_edge[3], m_in[3]);
        end
      end
      checks++; if (n_rise != int'(mb[0])) begin errors++; $display("FAIL edge_rise_count mode=%0d: got %0d expected %0d", m, n_rise, mb[0]); end
      checks++; if (n_fall != int'(mb[1])) begin errors++; $display("FAIL edge_fall_count mode=%0d: got %0d expected %0d", m, n_fall, mb[1]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    cfg[4] = 6'b001100;
    repeat (6) begin
      tb_val[4] = ~tb_val[4];
      tick();
      if (edge_o[4]) n++;
      checks++; if (edge_o[4] !== m_edge[4]) begin errors++; $display("FAIL b2b_edge: got %b expected %b", edge_o[4], m_edge[4]); end
    end
    repeat (3) begin
      tick();
      if (edge_o[4]) n++;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL b2b_count: got %0d expected 6", n); end
  endtask

  task automatic test_freeze();
    tb_en[0] = 1'b0; oe_i[0] = 1'b1; out_i[0] = 1'b1;
    tick();
    checks++; if (dut.oen_s[0] !== 1'b0 || dut.pad_i_s[0] !== 1'b1) begin errors++; $display("FAIL out_lat: got oen=%b i=%b expected 0 1", dut.oen_s[0], dut.pad_i_s[0]); end
    freeze = 1'b1; oe_i[0] = 1'b0; out_i[0] = 1'b0; tb_val[1] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (io[0] !== 1'b1 || dut.oen_s[0] !== 1'b0) begin errors++; $display("FAIL freeze_hold e=%0d: got io=%b oen=%b expected 1 0", e, io[0], dut.oen_s[0]); end
      checks++;
      if (in_o[1] !== (e >= 3)) begin errors++; $display("FAIL freeze_input e=%0d: got %b expected %b", e, in_o[1], (e >= 3)); end
    end
    freeze = 1'b0;
    tick();
    checks++; if (dut.oen_s[0] !== 1'b1) begin errors++; $display("FAIL unfreeze: got oen=%b expected 1", dut.oen_s[0]); end
    tb_en[0] = 1'b1;
  endtask

  task automatic test_mid_reset();
    tb_en[2:0] = 3'b000; oe_i[2:0] = 3'b111; out_i[2:0] = 3'b101;
    cfg[7] = 6'b000010; thr = 8'd8; tb_val[7] = 1'b0;
    repeat (5) tick();
    checks++; if (dut.oen_s[2:0] !== 3'b000 || in_o !== m_in) begin errors++; $display("FAIL pre_reset: got oen=%b in=%h expected 000 %h", dut.oen_s[2:0], in_o, m_in); end
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    checks++; if (dut.oen_s !== '1) begin errors++; $display("FAIL mid_reset_oen: got %h expected all ones", dut.oen_s); end
    checks++; if (in_o !== '0 || edge_o !== '0) begin errors++; $display("FAIL mid_reset_out: got in=%h edge=%h expected 0 0", in_o, edge_o); end
    tb_en = '1; oe_i = '0; out_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (12) tick();
    checks++; if (in_o !== m_in) begin errors++; $display("FAIL post_mid_reset: got %h expected %h", in_o, m_in); end
  endtask

  task automatic test_filter_disable();
    cfg[9] = 6'b000010; thr = 8'd10; tb_val[9] = 1'b1;
    repeat (5) tick();
    checks++; if (in_o[9] !== 1'b0) begin errors++; $display("FAIL fdis_counting: got %b expected 0", in_o[9]); end
    cfg[9] = 6'b000000;
    tick();
    checks++; if (in_o[9] !== 1'b1) begin errors++; $display("FAIL fdis_bypass: got %b expected 1", in_o[9]); end
    checks++; if (in_o !== m_in) begin errors++; $display("FAIL fdis_model: got %h expected %h", in_o, m_in); end
  endtask

  task automatic test_pull();
    cfg[0][0] = 1'b1; cfg[N-1][0] = 1'b1;
    #1;
    checks++; if (dut.pen_s[0] !== 1'b0 || dut.pen_s[N-1] !== 1'b0) begin errors++; $display("FAIL pull_on: got %b %b expected 0 0", dut.pen_s[0], dut.pen_s[N-1]); end
    cfg[0][0] = 1'b0; cfg[N-1][0] = 1'b0;
    #1;
    checks++; if (dut.pen_s[0] !== 1'b1 || dut.pen_s[N-1] !== 1'b1) begin errors++; $display("FAIL pull_off: got %b %b expected 1 1", dut.pen_s[0], dut.pen_s[N-1]); end
  endtask

  task automatic test_random();
    logic [N-1:0] mask, exp_pen;
    mask  = {{(N-16){1'b1}}, 16'h0000};
    tb_en = mask;
    for (int c = 0; c < 400; c++) begin
      for (int k = 16; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) tb_val[k] = ~tb_val[k];
      end
      if ($urandom_range(0, 3) == 0) cfg[$urandom_range(0, N-1)] = NB'($urandom);
      if ($urandom_range(0, 31) == 0) thr = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
      oe_i  = {{(N-16){1'b0}}, 16'($urandom)};
      out_i = {{(N-16){1'b0}}, 16'($urandom)};
      tick();
      for (int k = 0; k < N; k++) exp_pen[k] = ~cfg[k][0];
      checks++; if ((in_o & mask) !== (m_in & mask)) begin errors++; $display("FAIL rand_in c=%0d: got %h expected %h", c, in_o & mask, m_in & mask); end
      checks++; if ((edge_o & mask) !== (m_edge & mask)) begin errors++; $display("FAIL rand_edge c=%0d: got %h expected %h", c, edge_o & mask, m_edge & mask); end
      checks++; if (dut.oen_s !== ~m_oe || dut.pad_i_s !== m_out) begin errors++; $display("FAIL rand_out c=%0d: got oen=%h i=%h expected %h %h", c, dut.oen_s, dut.pad_i_s, ~m_oe, m_out); end
      checks++; if (dut.pen_s !== exp_pen) begin errors++; $display("FAIL rand_pen c=%0d: got %h expected %h", c, dut.pen_s, exp_pen); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_debounce();
    test_edge_modes();
    test_back_to_back();
    test_freeze();
    test_mid_reset();
    test_filter_disable();
    test_pull();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
